// File: rtl/router_pkg.sv
// Shared types and helpers for the NoC router input stage: direction encoding,
// flit header field positions and the XY route function.
package router_pkg;

   typedef enum logic [2:0] {
      DIR_LOCAL = 3'd0,
      DIR_NORTH = 3'd1,
      DIR_SOUTH = 3'd2,
      DIR_EAST  = 3'd3,
      DIR_WEST  = 3'd4
   } dir_t;

   localparam int unsigned COORD_W    = 4;
   localparam int unsigned DEST_X_LSB = 4;
   localparam int unsigned DEST_Y_LSB = 0;

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   function automatic dir_t xy_route(input logic [COORD_W-1:0] dest_x,
                                     input logic [COORD_W-1:0] dest_y,
                                     input logic [COORD_W-1:0] my_x,
                                     input logic [COORD_W-1:0] my_y);
      dir_t dir;
      dir = DIR_LOCAL;
      if (dest_x > my_x)      dir = DIR_EAST;
      else if (dest_x < my_x) dir = DIR_WEST;
      else if (dest_y > my_y) dir = DIR_NORTH;
      else if (dest_y < my_y) dir = DIR_SOUTH;
      return dir;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Single valid/ready input FIFO with show-ahead head and occupancy output.
// DEPTH need not be a power of two; pointers wrap by explicit compare.
module router_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned FLIT_W = 32,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              in_ready,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  level
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Handshakes use registered flags only, so in_ready never depends on out_ready.
   always_comb begin
      push       = in_valid & in_ready;
      pop        = out_valid & out_ready;
      wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
      count_nxt  = count;
      if (push && !pop)      count_nxt = count + CNT_W'(1);
      else if (pop && !push) count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         in_ready  <= (count_nxt != CNT_W'(DEPTH));
         out_valid <= (count_nxt != '0);
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_flit;
   end

   // Masking keeps stale storage off the bus after reset or drain.
   always_comb begin
      out_flit = '0;
      if (out_valid) out_flit = mem[rd_ptr];
   end

   assign level = count;

endmodule

// File: rtl/router_in_queues.sv
// Bank of independent per-direction input FIFOs for a mesh NoC router.
// Optional macro ROUTER_RC_EN adds a combinational XY route of each queue head.
module router_in_queues
   import router_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 5,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned FLIT_W    = 32,
   parameter int unsigned MY_X      = 0,
   parameter int unsigned MY_Y      = 0,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             in_valid,
   input  logic [NUM_PORTS-1:0][FLIT_W-1:0] in_flit,
   output logic [NUM_PORTS-1:0]             in_ready,
   output logic [NUM_PORTS-1:0]             out_valid,
   output logic [NUM_PORTS-1:0][FLIT_W-1:0] out_flit,
   input  logic [NUM_PORTS-1:0]             out_ready,
   output logic [NUM_PORTS-1:0][2:0]        out_dir,
   output logic [NUM_PORTS-1:0][CNT_W-1:0]  level
);

   // Elaboration-time guard on parameter ranges, including router coordinates.
   if (NUM_PORTS < 1 || DEPTH < 2 || FLIT_W < 8 ||
       MY_X >= (1 << COORD_W) || MY_Y >= (1 << COORD_W)) begin : g_param_check
      $error("router_in_queues: illegal parameter value");
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      router_fifo #(
         .DEPTH  (DEPTH),
         .FLIT_W (FLIT_W)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[p]),
         .in_flit   (in_flit[p]),
         .in_ready  (in_ready[p]),
         .out_valid (out_valid[p]),
         .out_flit  (out_flit[p]),
         .out_ready (out_ready[p]),
         .level     (level[p])
      );
   end

`ifdef ROUTER_RC_EN
   // Route is computed from the head flit; an empty queue reports LOCAL.
   always_comb begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         out_dir[p] = 3'(DIR_LOCAL);
         if (out_valid[p]) begin
            out_dir[p] = 3'(xy_route(out_flit[p][DEST_X_LSB +: COORD_W],
                                     out_flit[p][DEST_Y_LSB +: COORD_W],
                                     COORD_W'(MY_X), COORD_W'(MY_Y)));
         end
      end
   end
`else
   assign out_dir = {NUM_PORTS{3'(DIR_LOCAL)}};
`endif

endmodule

// File: tb/tb_router_in_queues.sv
// Scoreboard bench for router_in_queues: a queue-based reference model per port,
// plus a DEPTH=3 single-port instance sharing port 0 stimulus.
module tb_router_in_queues;

   localparam int NP    = 5;
   localparam int DEPTH = 4;
   localparam int FW    = 32;

   logic                 clk;
   logic                 rst_n;
   logic [NP-1:0]        iv;
   logic [NP-1:0][FW-1:0] fl;
   logic [NP-1:0]        ordy;
   logic [NP-1:0]        in_ready;
   logic [NP-1:0]        out_valid;
   logic [NP-1:0][FW-1:0] out_flit;
   logic [NP-1:0][2:0]   out_dir;
   logic [NP-1:0][2:0]   level;

   logic [0:0]           d3_in_ready;
   logic [0:0]           d3_out_valid;
   logic [0:0][FW-1:0]   d3_out_flit;
   logic [0:0][2:0]      d3_out_dir;
   logic [0:0][1:0]      d3_level;

   router_in_queues #(.NUM_PORTS(NP), .DEPTH(DEPTH), .FLIT_W(FW), .MY_X(2), .MY_Y(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_flit(fl), .in_ready(in_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_ready(ordy),
      .out_dir(out_dir), .level(level));

   router_in_queues #(.NUM_PORTS(1), .DEPTH(3), .FLIT_W(FW), .MY_X(2), .MY_Y(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_flit(fl[0]), .in_ready(d3_in_ready),
      .out_valid(d3_out_valid), .out_flit(d3_out_flit), .out_ready(ordy[0]),
      .out_dir(d3_out_dir), .level(d3_level));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit mon_en      = 1'b0;

   // Reference: index NP models the DEPTH=3 instance fed from port 0.
   logic [FW-1:0] mq [NP+1][$];
   bit            acc [NP+1];

   function automatic int cap(input int p);
      return (p < NP) ? DEPTH : 3;
   endfunction

   function automatic logic [2:0] exp_dir(input bit vld, input logic [FW-1:0] f);
`ifdef ROUTER_RC_EN
      int dx, dy;
      dx = int'(f[7:4]);
      dy = int'(f[3:0]);
      if (!vld)   return 3'd0;
      if (dx > 2) return 3'd3;
      if (dx < 2) return 3'd4;
      if (dy > 2) return 3'd1;
      if (dy < 2) return 3'd2;
      return 3'd0;
`else
      return (vld && f[0] === 1'bx) ? 3'd7 : 3'd0;
`endif
   endfunction

   task automatic chk(input string name, input int p, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s port %0d at %0t: got %0h expected %0h", name, p, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p <= NP; p++) begin
            mq[p].delete();
            acc[p] = 1'b0;
         end
      end else begin
         for (int p = 0; p <= NP; p++) begin
            int  q;
            bit  do_pop, do_push;
            q       = (p < NP) ? p : 0;
            do_pop  = (mq[p].size() != 0) && ordy[q];
            do_push = iv[q] && (mq[p].size() < cap(p));
            if (do_pop)  void'(mq[p].pop_front());
            if (do_push) mq[p].push_back(fl[q]);
            acc[p] = do_push;
         end
      end
   end

   logic          m_rdy, m_vld;
   logic [FW-1:0] m_flit;
   logic [2:0]    m_dir;
   int            m_lvl;
   logic [FW-1:0] m_head;

   // Monitor: compares every port against the model each cycle, head flit in order.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int p = 0; p <= NP; p++) begin
            if (p < NP) begin
               m_rdy = in_ready[p]; m_vld = out_valid[p]; m_flit = out_flit[p];
               m_dir = out_dir[p];  m_lvl = int'(level[p]);
            end else begin
               m_rdy = d3_in_ready[0]; m_vld = d3_out_valid[0]; m_flit = d3_out_flit[0];
               m_dir = d3_out_dir[0];  m_lvl = int'(d3_level[0]);
            end
            m_head = (mq[p].size() != 0) ? mq[p][0] : '0;
            chk("level", p, FW'(m_lvl), FW'(mq[p].size()));
            chk("in_ready", p, FW'(m_rdy), FW'(mq[p].size() != cap(p)));
            chk("out_valid", p, FW'(m_vld), FW'(mq[p].size() != 0));
            chk("out_dir", p, FW'(m_dir), FW'(exp_dir(mq[p].size() != 0, m_head)));
            if (mq[p].size() != 0) chk("out_flit", p, m_flit, m_head);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input int p, input int n, input logic [FW-1:0] base);
      for (int i = 0; i < n; i++) begin
         iv[p] = 1'b1;
         fl[p] = base + FW'(i);
         step();
      end
      iv[p] = 1'b0;
   endtask

   logic [2:0] route_exp [5];
   logic [7:0] route_hdr [5];

   initial begin
      rst_n = 1'b0;
      iv    = '0;
      fl    = '0;
      ordy  = '0;
      repeat (3) step();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      // Reset mid-burst on port 2.
      push_n(2, 3, 32'h0000_C200);
      iv[2] = 1'b1; fl[2] = 32'h0000_C2FF;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", -1, FW'(in_ready), FW'({NP{1'b1}}));
      chk("rst_out_valid", -1, FW'(out_valid), '0);
      chk("rst_level", -1, FW'(level), '0);
      chk("rst_out_flit", 2, out_flit[2], '0);
      step();
      iv[2] = 1'b0;
      rst_n = 1'b1;
      step();

      // Fill/drain port 0.
      push_n(0, 4, 32'h0000_00A1);
      @(negedge clk);
      chk("fill_level", 0, FW'(level[0]), 32'd4);
      chk("fill_in_ready", 0, FW'(in_ready[0]), 32'd0);
      iv[0] = 1'b1; fl[0] = 32'h0000_00A5;
      step(); step();
      @(negedge clk);
      chk("full_reject_level", 0, FW'(level[0]), 32'd4);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("drain_head", 0, out_flit[0], 32'h0000_00A2);
         if (i == 3) chk("drain_empty", 0, FW'(out_valid[0]), 32'd0);
         step();
      end
      ordy[0] = 1'b0;

      // Concurrent push+pop at level 2 across pointer wrap.
      push_n(0, 2, 32'h0000_0C00);
      for (int i = 0; i < 10; i++) begin
         iv[0] = 1'b1; fl[0] = 32'h0000_0C02 + FW'(i); ordy[0] = 1'b1;
         step();
         @(negedge clk);
         chk("conc_level", 0, FW'(level[0]), 32'd2);
         chk("conc_head", 0, out_flit[0], 32'h0000_0C01 + FW'(i));
      end
      iv[0] = 1'b0;
      repeat (3) step();
      ordy[0] = 1'b0;

      // Full + pop + held in_valid.
      push_n(0, 4, 32'h0000_00B1);
      iv[0] = 1'b1; fl[0] = 32'h0000_00B5; ordy[0] = 1'b1;
      step();
      @(negedge clk);
      chk("fullpop_level", 0, FW'(level[0]), 32'd3);
      chk("fullpop_ready", 0, FW'(in_ready[0]), 32'd1);
      ordy[0] = 1'b0;
      step();
      @(negedge clk);
      chk("held_accept", 0, FW'(level[0]), 32'd4);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      repeat (5) step();
      ordy[0] = 1'b0;

      // Port isolation: port 1 stalled full, port 3 streams.
      push_n(1, 4, 32'h0000_1100);
      iv[1] = 1'b1; fl[1] = 32'h0000_11FF;
      for (int i = 0; i < 12; i++) begin
         iv[3] = 1'b1; fl[3] = 32'h0000_3300 + FW'(i); ordy[3] = 1'b1;
         step();
         @(negedge clk);
         chk("iso_p3_level", 3, FW'(level[3]), 32'd1);
         chk("iso_p3_head", 3, out_flit[3], 32'h0000_3300 + FW'(i));
         chk("iso_p1_level", 1, FW'(level[1]), 32'd4);
      end
      iv[1] = 1'b0; iv[3] = 1'b0; ordy[1] = 1'b1;
      repeat (5) step();
      ordy = '0;

      // Route compute on port 4 (router at 2,2).
      route_hdr[0] = 8'h30; route_hdr[1] = 8'h15; route_hdr[2] = 8'h25;
      route_hdr[3] = 8'h21; route_hdr[4] = 8'h22;
`ifdef ROUTER_RC_EN
      route_exp[0] = 3'd3; route_exp[1] = 3'd4; route_exp[2] = 3'd1;
      route_exp[3] = 3'd2; route_exp[4] = 3'd0;
`else
      for (int i = 0; i < 5; i++) route_exp[i] = 3'd0;
`endif
      for (int i = 0; i < 5; i++) begin
         iv[4] = 1'b1; fl[4] = {$urandom_range(0, 32'hFF_FFFF)} << 8 | FW'(route_hdr[i]);
         step();
         iv[4] = 1'b0;
         @(negedge clk);
         chk("route", 4, FW'(out_dir[4]), FW'(route_exp[i]));
         ordy[4] = 1'b1;
         step();
         ordy[4] = 1'b0;
         @(negedge clk);
         chk("route_empty", 4, FW'(out_dir[4]), 32'd0);
      end

      // Random traffic with one mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         int pv, pr;
         pv = (c < 1500) ? 70 : 35;
         pr = (c < 1500) ? 40 : 80;
         for (int p = 0; p < NP; p++) begin
            if (!(iv[p] && !acc[p])) begin
               iv[p] = ($urandom_range(0, 99) < pv);
               fl[p] = $urandom;
            end
            ordy[p] = ($urandom_range(0, 99) < pr);
         end
         if (c == 1000) rst_n = 1'b0;
         if (c == 1002) rst_n = 1'b1;
         step();
      end
      iv = '0; ordy = '1;
      repeat (8) step();
      @(negedge clk);
      chk("final_empty", -1, FW'(out_valid), '0);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
